// File: rtl/vend_controller.sv
// Vending transaction controller: coin credit accumulation, two-product
// selection against price and stock, dispenser req/ack handshake, and
// change payout as an alternating pulse train.
module vend_controller #(
  parameter int PRICE_A     = 5,
  parameter int PRICE_B     = 3,
  parameter int MAX_CREDIT  = 10,
  parameter int STOCK_INIT  = 8,
  parameter int TIMEOUT_CYC = 500
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] i_money,
  input  logic [1:0] i_sel,
  input  logic       i_cancel,
  input  logic       i_refill,
  input  logic       i_disp_ack,
  output logic       o_disp_req,
  output logic       o_disp_sel,
  output logic       o_change,
  output logic       o_coin_reject,
  output logic       o_deny,
  output logic       o_busy,
  output logic [3:0] o_credit
);

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [4:0]    PA        = 5'(PRICE_A);
  localparam logic [4:0]    PB        = 5'(PRICE_B);
  localparam logic [4:0]    MAXC      = 5'(MAX_CREDIT);
  localparam logic [7:0]    STOCK_RST = 8'(STOCK_INIT);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [7:0]    stock_a;
  logic [7:0]    stock_b;
  logic [TW-1:0] tmo_cnt;

  logic [4:0] coin_val;
  logic [4:0] credit_w;
  logic [4:0] price;
  logic [4:0] base;
  logic [4:0] sum;
  logic       coin_any;
  logic       sel_a;
  logic       sel_b;
  logic       sel_any;
  logic       sel_ok;
  logic       sel_accept;
  logic       coin_fits;

  // Decode coin/selection and evaluate price, stock and credit ceiling.
  // Selection is judged on registered credit; the coin is then checked
  // against the credit left after any price deduction.
  always_comb begin
    coin_val = '0;
    case (i_money)
      2'd1:    coin_val = 5'd1;
      2'd2:    coin_val = 5'd2;
      default: coin_val = '0;
    endcase
    coin_any   = (i_money != 2'd0);
    sel_a      = (i_sel == 2'b01);
    sel_b      = (i_sel == 2'b10);
    sel_any    = sel_a | sel_b;
    credit_w   = {1'b0, o_credit};
    price      = sel_b ? PB : PA;
    sel_ok     = (sel_a && (credit_w >= PA) && (stock_a != '0)) ||
                 (sel_b && (credit_w >= PB) && (stock_b != '0));
    sel_accept = !i_cancel && sel_ok;
    base       = sel_accept ? (credit_w - price) : credit_w;
    sum        = base + coin_val;
    coin_fits  = (coin_val != '0) && (sum <= MAXC);
  end

  // Transaction FSM with stock bookkeeping and registered outputs.
  // Entering CHANGE emits the first pulse immediately; CHANGE then
  // alternates low/high until the credit is exhausted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      stock_a       <= STOCK_RST;
      stock_b       <= STOCK_RST;
      tmo_cnt       <= '0;
      o_disp_req    <= 1'b0;
      o_disp_sel    <= 1'b0;
      o_change      <= 1'b0;
      o_coin_reject <= 1'b0;
      o_deny        <= 1'b0;
      o_busy        <= 1'b0;
      o_credit      <= '0;
    end else begin
      o_coin_reject <= 1'b0;
      o_deny        <= 1'b0;
      if (i_refill) begin
        stock_a <= STOCK_RST;
        stock_b <= STOCK_RST;
      end
      case (state)
        IDLE: begin
          if (sel_any) o_deny <= 1'b1;
          if (coin_val != '0) begin
            o_credit <= coin_val[3:0];
            tmo_cnt  <= '0;
            state    <= CREDIT;
          end else if (coin_any) begin
            o_coin_reject <= 1'b1;
          end
        end
        CREDIT: begin
          if (coin_any && !coin_fits) o_coin_reject <= 1'b1;
          if (i_cancel) begin
            state    <= CHANGE;
            o_busy   <= 1'b1;
            o_change <= 1'b1;
            o_credit <= (coin_fits ? sum[3:0] : o_credit) - 4'd1;
          end else if (sel_accept) begin
            if (!i_refill) begin
              if (sel_b) stock_b <= stock_b - 8'd1;
              else       stock_a <= stock_a - 8'd1;
            end
            o_credit   <= coin_fits ? sum[3:0] : base[3:0];
            o_disp_sel <= sel_b;
            o_disp_req <= 1'b1;
            o_busy     <= 1'b1;
            state      <= DISPENSE;
          end else begin
            if (sel_any)   o_deny   <= 1'b1;
            if (coin_fits) o_credit <= sum[3:0];
            if (coin_any || sel_any) begin
              tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
              state    <= CHANGE;
              o_busy   <= 1'b1;
              o_change <= 1'b1;
              o_credit <= o_credit - 4'd1;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
        end
        DISPENSE: begin
          if (coin_any) o_coin_reject <= 1'b1;
          if (sel_any)  o_deny        <= 1'b1;
          if (i_disp_ack) begin
            o_disp_req <= 1'b0;
            if (o_credit != '0) begin
              state    <= CHANGE;
              o_change <= 1'b1;
              o_credit <= o_credit - 4'd1;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        CHANGE: begin
          if (coin_any) o_coin_reject <= 1'b1;
          if (sel_any)  o_deny        <= 1'b1;
          if (o_change) begin
            o_change <= 1'b0;
            if (o_credit == '0) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else if (o_credit != '0) begin
            o_change <= 1'b1;
            o_credit <= o_credit - 4'd1;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: a transaction-level model queues
// expected per-cycle status and pulse events; a monitor pops and compares.
module tb_vend_controller;

  localparam int PRICE_A     = 5;
  localparam int PRICE_B     = 3;
  localparam int MAX_CREDIT  = 10;
  localparam int STOCK_INIT  = 8;
  localparam int TIMEOUT_CYC = 500;

  localparam int M_IDLE = 0;
  localparam int M_CR   = 1;
  localparam int M_DISP = 2;
  localparam int M_REF  = 3;

  logic       sys_clk    = 1'b0;
  logic       sys_rst_n  = 1'b0;
  logic [1:0] i_money    = '0;
  logic [1:0] i_sel      = '0;
  logic       i_cancel   = 1'b0;
  logic       i_refill   = 1'b0;
  logic       i_disp_ack = 1'b0;
  logic       o_disp_req;
  logic       o_disp_sel;
  logic       o_change;
  logic       o_coin_reject;
  logic       o_deny;
  logic       o_busy;
  logic [3:0] o_credit;

  vend_controller #(
    .PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .MAX_CREDIT(MAX_CREDIT),
    .STOCK_INIT(STOCK_INIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_money(i_money), .i_sel(i_sel),
    .i_cancel(i_cancel), .i_refill(i_refill), .i_disp_ack(i_disp_ack),
    .o_disp_req(o_disp_req), .o_disp_sel(o_disp_sel), .o_change(o_change),
    .o_coin_reject(o_coin_reject), .o_deny(o_deny), .o_busy(o_busy),
    .o_credit(o_credit)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int n;
    int credit;
    bit busy;
    bit req;
    bit dsel;
  } stat_t;

  stat_t q_stat[$];
  int    q_rej[$];
  int    q_deny[$];
  int    q_disp[$];
  int    q_chg[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b1;
  int mon_n    = 0;
  bit prev_req = 1'b0;

  // Reference model state
  int m_mode   = M_IDLE;
  int m_credit = 0;
  int m_stock[2];
  int m_idle   = 0;
  int m_rs     = 0;
  int m_k      = 0;
  bit m_dsel   = 1'b0;
  int drv_n    = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, drv_n, act, exp);
    end
  endtask

  task automatic start_refund(input int n);
    m_rs     = n;
    m_k      = m_credit;
    m_mode   = M_REF;
    m_credit = m_credit - 1;
    q_chg.push_back(n);
  endtask

  // One clock edge of the specified behaviour, expressed on abstract credit/stock.
  task automatic model_step(input int n, input int money, input int sel,
                            input bit cancel, input bit refill, input bit ack);
    int coinv;
    int selx;
    int off;
    int price[2];
    bit is_coin;
    bit ok;
    price[0] = PRICE_A;
    price[1] = PRICE_B;
    coinv    = (money == 1) ? 1 : ((money == 2) ? 2 : 0);
    is_coin  = (money != 0);
    selx     = (sel == 1) ? 0 : ((sel == 2) ? 1 : -1);
    ok       = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (selx >= 0) q_deny.push_back(n);
        if (coinv > 0) begin
          m_credit = coinv;
          m_mode   = M_CR;
          m_idle   = 0;
        end else if (is_coin) begin
          q_rej.push_back(n);
        end
      end
      M_CR: begin
        if (cancel) begin
          if (coinv > 0 && m_credit + coinv <= MAX_CREDIT) m_credit += coinv;
          else if (is_coin) q_rej.push_back(n);
          start_refund(n);
        end else begin
          if (selx >= 0) ok = (m_credit >= price[selx]) && (m_stock[selx] > 0);
          if (ok) begin
            if (!refill) m_stock[selx]--;
            m_credit -= price[selx];
            m_dsel    = (selx == 1);
            m_mode    = M_DISP;
            q_disp.push_back(n);
          end else if (selx >= 0) begin
            q_deny.push_back(n);
          end
          if (coinv > 0 && m_credit + coinv <= MAX_CREDIT) m_credit += coinv;
          else if (is_coin) q_rej.push_back(n);
          if (!ok) begin
            if (is_coin || selx >= 0) m_idle = 0;
            else begin
              m_idle++;
              if (m_idle == TIMEOUT_CYC) start_refund(n);
            end
          end
        end
      end
      M_DISP: begin
        if (is_coin) q_rej.push_back(n);
        if (selx >= 0) q_deny.push_back(n);
        if (ack) begin
          if (m_credit > 0) start_refund(n);
          else m_mode = M_IDLE;
        end
      end
      default: begin
        if (is_coin) q_rej.push_back(n);
        if (selx >= 0) q_deny.push_back(n);
        off = n - m_rs;
        if (off % 2 == 0) begin
          m_credit--;
          q_chg.push_back(n);
        end
        if (off == 2 * m_k - 1) m_mode = M_IDLE;
      end
    endcase
    if (refill) begin
      m_stock[0] = STOCK_INIT;
      m_stock[1] = STOCK_INIT;
    end
    q_stat.push_back('{n, m_credit, (m_mode == M_DISP) || (m_mode == M_REF),
                       (m_mode == M_DISP), m_dsel});
  endtask

  task automatic cycle(input int money, input int sel, input bit cancel = 1'b0,
                       input bit refill = 1'b0, input bit ack = 1'b0);
    @(negedge sys_clk);
    i_money    = 2'(money);
    i_sel      = 2'(sel);
    i_cancel   = cancel;
    i_refill   = refill;
    i_disp_ack = ack;
    model_step(drv_n, money, sel, cancel, refill, ack);
    drv_n++;
  endtask

  task automatic sample;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_count(input int ncyc, output int pulses);
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      cycle(0, 0);
      sample();
      if (o_change === 1'b1) pulses++;
    end
  endtask

  task automatic ev_check(input int kind, input logic seen, input int n);
    bit    exp_ev;
    string name;
    exp_ev = 1'b0;
    case (kind)
      0: begin
        name = "coin_reject";
        if (q_rej.size() > 0 && q_rej[0] == n) begin exp_ev = 1'b1; void'(q_rej.pop_front()); end
      end
      1: begin
        name = "deny";
        if (q_deny.size() > 0 && q_deny[0] == n) begin exp_ev = 1'b1; void'(q_deny.pop_front()); end
      end
      2: begin
        name = "disp_start";
        if (q_disp.size() > 0 && q_disp[0] == n) begin exp_ev = 1'b1; void'(q_disp.pop_front()); end
      end
      default: begin
        name = "change_pulse";
        if (q_chg.size() > 0 && q_chg[0] == n) begin exp_ev = 1'b1; void'(q_chg.pop_front()); end
      end
    endcase
    if (exp_ev || seen !== 1'b0) chk(name, {31'd0, seen}, {31'd0, exp_ev});
  endtask

  // Monitor: compares every post-edge output against the queued expectation.
  initial begin
    stat_t s;
    wait (sys_rst_n === 1'b1);
    forever begin
      @(posedge sys_clk);
      #1;
      if (mon_en) begin
        mon_n++;
        if (q_stat.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL status: nothing queued for cycle %0d", mon_n);
        end else begin
          s = q_stat.pop_front();
          chk("credit", 32'(o_credit), s.credit);
          chk("busy", {31'd0, o_busy}, {31'd0, s.busy});
          chk("disp_req", {31'd0, o_disp_req}, {31'd0, s.req});
          if (s.req) chk("disp_sel", {31'd0, o_disp_sel}, {31'd0, s.dsel});
        end
        ev_check(0, o_coin_reject, mon_n);
        ev_check(1, o_deny, mon_n);
        ev_check(2, o_disp_req && !prev_req, mon_n);
        ev_check(3, o_change, mon_n);
        prev_req = o_disp_req;
      end
    end
  end

  // Stimulus: directed scenarios, random traffic, then reset abort.
  initial begin
    int p;
    int r;
    int money;
    int sel;
    m_stock[0] = STOCK_INIT;
    m_stock[1] = STOCK_INIT;

    repeat (2) @(negedge sys_clk);
    chk("rst credit", 32'(o_credit), 0);
    chk("rst outputs", {25'd0, o_disp_req, o_disp_sel, o_change, o_coin_reject,
                        o_deny, o_busy, 1'b0}, 0);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b1;

    // Exact-price purchase of A, no change
    cycle(2, 0); cycle(2, 0); cycle(1, 0);
    sample(); chk("credit 2+2+1", 32'(o_credit), 5);
    cycle(0, 1);
    sample(); chk("A req", {31'd0, o_disp_req}, 1); chk("A sel", {31'd0, o_disp_sel}, 0);
    cycle(0, 0, 0, 0, 1);
    sample(); chk("A ack req", {31'd0, o_disp_req}, 0); chk("A no change", {31'd0, o_change}, 0);
    chk("A idle", {31'd0, o_busy}, 0);

    // B with 3 units change
    cycle(2, 0); cycle(2, 0); cycle(2, 0); cycle(0, 2);
    sample(); chk("B sel", {31'd0, o_disp_sel}, 1);
    cycle(0, 0, 0, 0, 1);
    sample(); chk("first change after ack", {31'd0, o_change}, 1);
    run_count(6, p);
    chk("B change pulses", p + 1, 3); chk("B credit end", 32'(o_credit), 0);
    chk("B idle", {31'd0, o_busy}, 0);

    // Deny, ceiling reject, invalid coin, cancel refund
    cycle(2, 0); cycle(1, 0); cycle(0, 1);
    sample(); chk("deny A", {31'd0, o_deny}, 1); chk("deny credit", 32'(o_credit), 3);
    cycle(2, 0); cycle(2, 0); cycle(2, 0);
    cycle(2, 0);
    sample(); chk("ceiling reject", {31'd0, o_coin_reject}, 1); chk("ceiling credit", 32'(o_credit), 9);
    cycle(3, 0);
    sample(); chk("invalid coin", {31'd0, o_coin_reject}, 1);
    cycle(0, 0, 1);
    sample(); chk("cancel pulse", {31'd0, o_change}, 1);
    run_count(20, p);
    chk("cancel refund", p + 1, 9); chk("cancel credit end", 32'(o_credit), 0);

    // Timeout refund
    cycle(2, 0); cycle(1, 0);
    run_count(TIMEOUT_CYC - 1, p);
    chk("pre-timeout pulses", p, 0); chk("pre-timeout credit", 32'(o_credit), 3);
    run_count(8, p);
    chk("timeout refund", p, 3); chk("timeout idle", {31'd0, o_busy}, 0);

    // Stock exhaustion and refill
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(2, 0); cycle(1, 0); cycle(0, 2); cycle(0, 0, 0, 0, 1); cycle(0, 0);
    end
    cycle(2, 0); cycle(1, 0); cycle(0, 2);
    sample(); chk("B sold out deny", {31'd0, o_deny}, 1); chk("sold out req", {31'd0, o_disp_req}, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 2);
    sample(); chk("B after refill", {31'd0, o_disp_req}, 1);
    cycle(0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r     = $urandom_range(0, 9);
      money = (r < 4) ? 0 : ((r < 6) ? 1 : ((r < 9) ? 2 : 3));
      r     = $urandom_range(0, 7);
      sel   = (r == 0) ? 1 : ((r == 1) ? 2 : ((r == 2) ? 3 : 0));
      cycle(money, sel, ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 60 && m_mode != M_IDLE; i++) cycle(0, 0, 1, 0, 1);
    cycle(0, 0);
    sample(); chk("drain busy", {31'd0, o_busy}, 0); chk("drain credit", 32'(o_credit), 0);

    // Dispense ignores coins and cancel; reset aborts
    cycle(2, 0, 0, 1); cycle(2, 0); cycle(2, 0); cycle(0, 1);
    sample(); chk("6 A req", {31'd0, o_disp_req}, 1); chk("6 A credit", 32'(o_credit), 1);
    cycle(2, 0);
    sample(); chk("disp coin reject", {31'd0, o_coin_reject}, 1);
    cycle(0, 0, 1);
    sample(); chk("disp cancel ignored", {31'd0, o_disp_req}, 1);
    chk("disp cancel no change", {31'd0, o_change}, 0);
    #1;
    mon_en = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("abort req", {31'd0, o_disp_req}, 0); chk("abort credit", 32'(o_credit), 0);
    chk("abort busy", {31'd0, o_busy}, 0);

    chk("leftover status", q_stat.size(), 0);
    chk("leftover reject", q_rej.size(), 0);
    chk("leftover deny", q_deny.size(), 0);
    chk("leftover dispense", q_disp.size(), 0);
    chk("leftover change", q_chg.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
